// File: rtl/line_burst_bridge.sv
`timescale 1ns/1ps
// line_burst_bridge
//   Moves one cache line (BURST_LEN beats of DATA_W) or one single peripheral
//   word between the cache-side request port and a REQ/ACK/STALL memory bus.
//   Line accesses run INCR (from the line base) or WRAP (critical word first).
//   Single accesses use the byte strobes in req_sel_i.
//
// Optional feature: define BRIDGE_TIMEOUT_EN to build a beat watchdog.
//   A beat left pending for TIMEOUT_CYCLES cycles is aborted, and err_o is
//   raised alongside done_o. Without the macro, err_o is constant 0.
//
// Ports
//   clk, reset_n       clock, async active-low reset
//   freeze             holds every register and output
//   req_valid_i/ready  request handshake; fields are captured on accept
//   req_addr_i/we/single/wrap/sel, wr_line_i   request fields
//   rd_line_o          assembled read line (single read fills one slot)
//   done_o, err_o      completion pulse, timeout abort flag
//   ADDR/BURST/REQ/WRB/WDATA/BSTROBE  memory bus outputs
//   RDATA/ACK/STALL                   memory bus inputs
module line_burst_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          freeze,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_addr_i,
  input  logic                          req_we_i,
  input  logic                          req_single_i,
  input  logic                          req_wrap_i,
  input  logic [DATA_W/8-1:0]           req_sel_i,
  input  logic [BURST_LEN*DATA_W-1:0]   wr_line_i,
  output logic [BURST_LEN*DATA_W-1:0]   rd_line_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [ADDR_W-1:0]             ADDR,
  output logic [1:0]                    BURST,
  output logic                          REQ,
  output logic                          WRB,
  output logic [DATA_W-1:0]             WDATA,
  output logic [DATA_W/8-1:0]           BSTROBE,
  input  logic [DATA_W-1:0]             RDATA,
  input  logic                          ACK,
  input  logic                          STALL
);

  localparam int SEL_W      = DATA_W / 8;
  localparam int W          = $clog2(SEL_W);
  localparam int B          = $clog2(BURST_LEN);
  localparam int LINE_W     = BURST_LEN * DATA_W;
  localparam int LINE_BYTES = SEL_W * BURST_LEN;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_SINGLE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;     // line base, word-in-line bits cleared
  logic [B-1:0]       r_idx;      // current slot; wraps modulo BURST_LEN
  logic [B-1:0]       r_cnt;      // completed beats of the current line
  logic               r_we;
  logic [1:0]         r_burst;
  logic [SEL_W-1:0]   r_bstrobe;
  logic [LINE_W-1:0]  r_wline;
  logic [LINE_W-1:0]  r_rd_line;
  logic               r_err;

  logic w_accept, w_req, w_beat_done, w_last, w_tmo_fire;

  assign w_req       = (r_state == S_BURST) || (r_state == S_SINGLE);
  assign req_ready_o = (r_state == S_IDLE) && !freeze;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_beat_done = w_req && ACK && !STALL && !freeze;
  assign w_last      = (r_state == S_SINGLE) || (r_cnt == B'(BURST_LEN - 1));

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Counts pending-beat cycles; restarts on every completed beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_tmo <= '0;
    else if (!freeze) begin
      if (!w_req || w_beat_done) r_tmo <= '0;
      else                       r_tmo <= r_tmo + 1'b1;
    end
  end

  // Fires on the cycle that would bring the count to TIMEOUT_CYCLES.
  assign w_tmo_fire = w_req && !freeze && !w_beat_done &&
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the expression is constant 0.
  assign w_tmo_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!freeze) begin
      unique case (r_state)
        S_IDLE:   if (req_valid_i) w_state_nxt = req_single_i ? S_SINGLE : S_BURST;
        S_BURST,
        S_SINGLE: if (w_tmo_fire || (w_beat_done && w_last)) w_state_nxt = S_DONE;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_burst   <= 2'b00;
      r_bstrobe <= '0;
      r_wline   <= '0;
      r_rd_line <= '0;
      r_err     <= 1'b0;
    end else if (!freeze) begin
      if (w_accept) begin
        r_addr    <= req_addr_i & ~ADDR_W'(LINE_BYTES - 1);
        // Single and WRAP start at the addressed word, INCR at the line base.
        r_idx     <= (req_single_i || req_wrap_i) ? B'(req_addr_i >> W) : '0;
        r_cnt     <= '0;
        r_we      <= req_we_i;
        r_burst   <= req_single_i ? 2'b00 : (req_wrap_i ? 2'b10 : 2'b01);
        r_bstrobe <= req_single_i ? req_sel_i : '1;
        r_wline   <= wr_line_i;
      end else if (w_beat_done) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
        if (!r_we) r_rd_line[r_idx*DATA_W +: DATA_W] <= RDATA;
      end
      // Set on the abort edge, so it is high exactly while in DONE.
      r_err <= w_tmo_fire;
    end
  end

  assign REQ       = w_req;
  assign WRB       = r_we && w_req;
  assign ADDR      = r_addr | (ADDR_W'(r_idx) << W);
  assign WDATA     = r_wline[r_idx*DATA_W +: DATA_W];
  assign BSTROBE   = r_bstrobe;
  assign BURST     = r_burst;
  assign rd_line_o = r_rd_line;
  assign done_o    = (r_state == S_DONE);
  assign err_o     = r_err;

endmodule

// File: tb/tb_line_burst_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for line_burst_bridge (32-bit words, 8-beat lines).
// Expected bus values and the read line come from a per-request model:
// beat j uses slot (start + j) mod 8, the address is the line base plus
// slot*4, and a read beat stores its RDATA in that slot.
module tb_line_burst_bridge;
  localparam int LW = 256;

  logic            clk = 1'b0;
  logic            reset_n, freeze, req_valid_i, req_we_i, req_single_i, req_wrap_i;
  logic [31:0]     req_addr_i, RDATA, ADDR, WDATA;
  logic [3:0]      req_sel_i, BSTROBE;
  logic [LW-1:0]   wr_line_i, rd_line_o;
  logic            req_ready_o, done_o, err_o, REQ, WRB, ACK, STALL;
  logic [1:0]      BURST;

  int ntests = 0, nfail = 0;
  logic [LW-1:0] mline = '0;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int ACK_LO = 85, STL_HI = 10;
`else
  localparam int ACK_LO = 30, STL_HI = 40;
`endif

  line_burst_bridge #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_single_i(req_single_i), .req_wrap_i(req_wrap_i),
    .req_sel_i(req_sel_i), .wr_line_i(wr_line_i), .rd_line_o(rd_line_o),
    .done_o(done_o), .err_o(err_o), .ADDR(ADDR), .BURST(BURST), .REQ(REQ), .WRB(WRB),
    .WDATA(WDATA), .BSTROBE(BSTROBE), .RDATA(RDATA), .ACK(ACK), .STALL(STALL));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [31:0] a, input bit we, input bit sgl, input bit wrp,
                      input logic [3:0] sel, input logic [LW-1:0] wl,
                      input int ack_pct, input int stl_pct, input bit pat,
                      input logic [7:0] stl_mask, input int frz_at, input int rst_at);
    int idx0, n, j, k, bcyc, cyc;
    bit ack, stl, frz;
    logic [31:0] rd;
    idx0 = (sgl || wrp) ? int'(a[4:2]) : 0;
    n    = sgl ? 1 : 8;
    chk("ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1; req_addr_i = a; req_we_i = we; req_single_i = sgl;
    req_wrap_i = wrp; req_sel_i = sel; wr_line_i = wl;
    tick();
    // Scramble the request fields: the bridge must use its captured copy.
    req_valid_i = 0; req_addr_i = $urandom; req_we_i = ~we; req_single_i = ~sgl;
    req_wrap_i = ~wrp; req_sel_i = ~sel; wr_line_i = ~wl;
    j = 0; bcyc = 0; cyc = 0;
    while (j < n && cyc < 500) begin
      k = (idx0 + j) % 8;
      chk("REQ", REQ, 1'b1);
      chk("ADDR", ADDR, (a & 32'hFFFF_FFE0) | 32'(k * 4));
      chk("BURST", BURST, sgl ? 2'b00 : (wrp ? 2'b10 : 2'b01));
      chk("WRB", WRB, we);
      chk("WDATA", WDATA, wl[k*32 +: 32]);
      chk("BSTROBE", BSTROBE, sgl ? sel : 4'hF);
      chk("done_busy", done_o, 1'b0);
      chk("rd_line_run", rd_line_o, mline);
      if (j == rst_at) begin
        ACK = 0; STALL = 0;
        #3 reset_n = 0;
        #1;
        chk("rst_REQ", REQ, 1'b0);
        chk("rst_ADDR", ADDR, 32'h0);
        chk("rst_BURST", BURST, 2'b00);
        chk("rst_rd_line", rd_line_o, '0);
        mline = '0;
        @(posedge clk); #1;
        reset_n = 1;
        tick();
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_REQ_after", REQ, 1'b0);
        return;
      end
      frz = (j == frz_at) && (bcyc < 5);
      if (frz) begin ack = 1; stl = 0; end
      else if (stl_mask[j] && bcyc < 3) begin ack = 1; stl = 1; end
      else begin
        ack = ($urandom_range(99) < ack_pct);
        stl = ($urandom_range(99) < stl_pct);
      end
      rd = pat ? 32'hA0 + 32'(j) : $urandom;
      freeze = frz; ACK = ack; STALL = stl; RDATA = rd;
      if (frz) begin #1; chk("ready_frz", req_ready_o, 1'b0); end
      if (ack && !stl && !frz) begin
        if (!we) mline[k*32 +: 32] = rd;
        j++; bcyc = 0;
      end else bcyc++;
      cyc++;
      tick();
    end
    ACK = 0; STALL = 0; freeze = 0;
    chk("beats_in_budget", j, n);
    chk("done", done_o, 1'b1);
    chk("REQ_off", REQ, 1'b0);
    chk("err", err_o, 1'b0);
    chk("rd_line", rd_line_o, mline);
    tick();
    chk("done_pulse", done_o, 1'b0);
    chk("ready_after", req_ready_o, 1'b1);
    chk("rd_hold", rd_line_o, mline);
  endtask

  initial begin
    logic [LW-1:0] wl;
    logic [31:0]   a;
    reset_n = 0; freeze = 0; req_valid_i = 0; req_addr_i = '0; req_we_i = 0;
    req_single_i = 0; req_wrap_i = 0; req_sel_i = '0; wr_line_i = '0;
    RDATA = '0; ACK = 0; STALL = 0;
    repeat (3) tick();
    chk("rst_REQ0", REQ, 1'b0);
    chk("rst_WRB0", WRB, 1'b0);
    chk("rst_done0", done_o, 1'b0);
    chk("rst_err0", err_o, 1'b0);
    chk("rst_ADDR0", ADDR, 32'h0);
    chk("rst_WDATA0", WDATA, 32'h0);
    chk("rst_BSTROBE0", BSTROBE, 4'h0);
    chk("rst_BURST0", BURST, 2'b00);
    chk("rst_rdline0", rd_line_o, '0);
    reset_n = 1;
    tick();
    chk("ready0", req_ready_o, 1'b1);

    // ACK with no request pending is ignored.
    ACK = 1; RDATA = 32'hDEAD_BEEF;
    repeat (3) tick();
    ACK = 0;
    chk("idle_ack_REQ", REQ, 1'b0);
    chk("idle_ack_done", done_o, 1'b0);
    chk("idle_ack_line", rd_line_o, mline);

    // INCR read, RDATA = 0xA0 + beat
    xfer(32'h0000_1044, 0, 0, 0, 4'h0, '0, 100, 0, 1, 8'h00, -1, -1);
    chk("incr_slot0", rd_line_o[31:0], 32'hA0);
    chk("incr_slot7", rd_line_o[255:224], 32'hA7);

    // WRAP read starting at slot 5
    xfer(32'h0000_1054, 0, 0, 1, 4'h0, '0, 100, 0, 1, 8'h00, -1, -1);
    chk("wrap_slot5", rd_line_o[191:160], 32'hA0);
    chk("wrap_slot4", rd_line_o[159:128], 32'hA7);

    // Line write with STALL on beats 2..4
    for (int s = 0; s < 8; s++) wl[s*32 +: 32] = 32'h1111_1111 * s;
    xfer(32'h0000_2000, 1, 0, 0, 4'h0, wl, 100, 0, 0, 8'b0001_1100, -1, -1);

    // Single write to slot 3
    xfer(32'h8000_000C, 1, 1, 0, 4'b0011, wl, 100, 0, 0, 8'h00, -1, -1);

    // Single read into slot 6, other slots untouched
    xfer(32'h0000_3018, 0, 1, 0, 4'b1111, '0, 100, 0, 0, 8'h00, -1, -1);

    // Freeze at beat 3, then reset at beat 4
    xfer(32'h0000_4000, 0, 0, 0, 4'h0, '0, 100, 0, 1, 8'h00, 3, 4);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      for (int s = 0; s < 8; s++) wl[s*32 +: 32] = $urandom;
      a = $urandom;
      xfer(a, 1'($urandom_range(1)), ($urandom_range(3) == 0), 1'($urandom_range(1)),
           4'($urandom), wl, ACK_LO + $urandom_range(100 - ACK_LO), $urandom_range(STL_HI),
           0, 8'h00, -1, -1);
    end

`ifdef BRIDGE_TIMEOUT_EN
    // Watchdog: ACK never comes, abort 16 cycles after REQ rises.
    req_valid_i = 1; req_addr_i = 32'h0000_5000; req_we_i = 0; req_single_i = 0;
    req_wrap_i = 0; req_sel_i = 4'h0; wr_line_i = '0;
    tick();
    req_valid_i = 0; ACK = 0;
    chk("tmo_req_rise", REQ, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) chk("tmo_no_done", done_o, 1'b0);
    end
    chk("tmo_done", done_o, 1'b1);
    chk("tmo_err", err_o, 1'b1);
    chk("tmo_REQ_off", REQ, 1'b0);
    chk("tmo_line", rd_line_o, mline);
    tick();
    chk("tmo_done_pulse", done_o, 1'b0);
    chk("tmo_err_clear", err_o, 1'b0);
`else
    chk("err_tied", err_o, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", ntests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/line_burst_bridge.md
Name: line_burst_bridge

Overview:
- Parametrised successor to the cache-line/memory router: moves one cache line (BURST_LEN beats of DATA_W) or one single peripheral word between the cache-side request port and the REQ/ACK/STALL memory bus.
- Adds per-request INCR or WRAP (critical-word-first) bursts, separate read and write line buses (no inout), a valid/ready request handshake and a done pulse.
- Sits between the D-cache/I-cache miss logic and the memory/peripheral fabric.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory bus word width; a power of two, at least 8.
- BURST_LEN, 8, beats per line; a power of two, at least 2. Line width LINE_W = BURST_LEN*DATA_W (local).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- freeze  in  1  pipeline freeze: all state, counters and outputs hold.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  bridge can accept a request.
- req_addr_i  in  ADDR_W  byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_single_i  in  1  single-word (peripheral) access.
- req_wrap_i  in  1  line access uses WRAP order starting at the addressed word; 0 = INCR from line base.
- req_sel_i  in  DATA_W/8  byte strobes for single access.
- wr_line_i  in  LINE_W  write line; slot k = bits [k*DATA_W +: DATA_W].
- rd_line_o  out  LINE_W  read line / single-word slot.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  timeout abort flag; only with the optional feature, else tied 0.
- ADDR  out  ADDR_W  memory address.
- BURST  out  2  00 single, 01 INCR, 10 WRAP.
- REQ  out  1  beat request.
- WRB  out  1  write beat.
- WDATA  out  DATA_W  write data.
- BSTROBE  out  DATA_W/8  byte strobes.
- RDATA  in  DATA_W  read data.
- ACK  in  1  beat acknowledge.
- STALL  in  1  memory stall.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - State → IDLE.
  - REQ, WRB, done_o, err_o = 0.
  - ADDR, WDATA, BSTROBE, BURST, rd_line_o = 0.
  - Beat counter = 0.
- Request acceptance:
  - req_ready_o = 1 only in IDLE with freeze = 0.
  - Accept when req_valid_i & req_ready_o. On accept, capture addr, we, sel, single, wrap and wr_line_i; the requester need not hold them afterwards.
- Beat completion: a beat completes in a cycle with REQ & ACK & ~STALL & ~freeze.
  - ADDR, WRB, WDATA and BSTROBE hold stable until the beat completes.
  - On completion: read data goes into rd_line_o slot idx; the next beat is presented the following cycle.
- Index rules (w = log2(DATA_W/8), b = log2(BURST_LEN)):
  - Start idx = addr[w+b-1:w] for WRAP and single accesses; 0 for INCR.
  - idx increments modulo BURST_LEN per beat.
  - ADDR = {addr[ADDR_W-1:w+b], idx, w zeros}.
  - WDATA = wr_line slot idx.
- FSM, state IDLE → BURST (line access) or SINGLE (single access) on accept. REQ rises in the cycle after accept.
- FSM, state BURST:
  - BURST = 01 or 10; BSTROBE all ones; WRB = captured we.
  - Beat counter counts completed beats.
  - After beat BURST_LEN-1 completes → DONE; REQ = 0 in the next cycle.
- FSM, state SINGLE:
  - BURST = 00; BSTROBE = captured sel.
  - One beat; read data lands in slot idx, other slots unchanged. → DONE.
- FSM, state DONE: done_o = 1 for exactly one cycle; rd_line_o complete and stable from this cycle until the next read completes a beat → IDLE.
- Freeze: no state, counter, output or capture change. An ACK during freeze is ignored; the memory side must not ACK while frozen.
- STALL with ACK: the beat does not complete; retry the same beat.
- ACK while REQ = 0: ignored.

Optional Feature:
- Macro BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter increments each unfrozen cycle with REQ = 1 and no beat completion; it clears on each completion.
  - On reaching TIMEOUT_CYCLES: abort the access, REQ = 0 next cycle, go to DONE with err_o = 1 alongside the done_o pulse.
  - rd_line_o holds the slots received so far.
- Undefined: no counter is built; err_o is constant 0.

Test Plan:
- INCR read, addr 0x0000_1044, wrap = 0, ACK every cycle, RDATA = 0xA0+beat:
  - ADDR must run 0x1040, 0x1044 … 0x105C; BURST = 01.
  - done_o fires 1 cycle after the 8th ACK.
  - rd_line_o slot k = 0xA0+k.
- WRAP read, addr 0x1054, wrap = 1:
  - ADDR must run 0x1054, 0x1058, 0x105C, 0x1040 … 0x1050; BURST = 10.
  - Slot 5 = first beat's RDATA.
- Line write, wr_line slot k = 0x1111_1111*k, STALL high on beats 2–4 for 3 cycles each:
  - WDATA/ADDR must hold during the stall.
  - WRB = 1 for all 8 beats; exactly 8 completions.
- Single write, addr 0x8000_000C, sel = 4'b0011:
  - BURST = 00, ADDR = 0x8000_000C, BSTROBE = 0011, WDATA = slot 3.
  - done_o after one ACK.
- Freeze then reset:
  - freeze for 5 cycles mid-burst: every output must hold.
  - Drop reset_n at beat 4: REQ = 0 immediately (asynchronously), req_ready_o = 1 after release.
- BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and ACK never asserted:
  - done_o and err_o must both be 1 exactly 16 cycles after REQ rises; REQ = 0 the next cycle.
